out_fifo_network: RTL and testbench

Egress counterpart of the ingress node-FIFO chain. Collects 142-bit words emitted by `ncount` processing nodes, buffers each node's output in its own FIFO, and merges them onto a single Avalon-ST source toward the Ethernet MAC. Arbitration is round-robin and packet-atomic: once a node's packet starts, it owns the output until its `eop` word is accepted.

---
 rtl/eth_pr_pkg.sv | 17 +
 rtl/out_node_fifo.sv | 38 +++
 rtl/out_fifo_network.sv | 100 ++++++++++
 tb/tb_out_fifo_network.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_pr_pkg.sv
// eth_pr_pkg: node word layout and widths shared by the ingress and egress paths
package eth_pr_pkg;
  localparam int word_w = 142;
  localparam int st_w = 148;
  typedef struct packed {
    logic [1:0]  channel;
    logic [9:0]  mid;
    logic        sop;
    logic        eop;
    logic [63:0] hi;
    logic [63:0] lo;
  } node_word_t;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  function automatic logic [st_w-1:0] to_st(input node_word_t w);
    return {10'b0, w.hi, w.mid, w.lo};
  endfunction
endpackage

// File: rtl/out_node_fifo.sv
// out_node_fifo: show-ahead per-node FIFO with almost_full at af_margin free slots
module out_node_fifo
  import eth_pr_pkg::*;
#(
  parameter int depth = 16,
  parameter int af_margin = 4
) (
  input  logic       clock,
  input  logic       sclr,
  input  logic       wr,
  input  logic       rd,
  input  node_word_t din,
  output node_word_t head,
  output logic       empty,
  output logic       almost_full
);
  localparam int aw = $clog2(depth);
  node_word_t mem [depth];
  logic [aw-1:0] wp, rp;
  logic [aw:0] cnt, free;
  always_ff @(posedge clock)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clock) begin
    if (sclr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + aw'(1);
      if (rd) rp <= rp + aw'(1);
      cnt <= cnt + (aw+1)'(wr) - (aw+1)'(rd);
    end
  end
  assign head = mem[rp];
  assign empty = cnt == '0;
  assign free = (aw+1)'(depth) - cnt;
  assign almost_full = free <= (aw+1)'(af_margin);
endmodule

// File: rtl/out_fifo_network.sv
// out_fifo_network: per-node egress FIFOs merged onto one Avalon-ST source by a
// packet-atomic round-robin arbiter
module out_fifo_network
  import eth_pr_pkg::*;
#(
  parameter int ncount = 8,
  parameter int fifo_depth = 16,
  parameter int af_margin = 4
) (
  input  logic              clock,
  input  logic              sclr,
  input  logic [word_w-1:0] pnode_data [ncount],
  input  logic [ncount-1:0] pnode_valid,
  output logic [ncount-1:0] pnode_ready,
  output logic [st_w-1:0]   st_data,
  output logic              st_sop,
  output logic              st_eop,
  output logic [1:0]        st_channel,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [15:0]       drop_count
);
  localparam int pw = $clog2(ncount);
  typedef logic [pw-1:0] idx_t;
  arb_state_t state, state_n;
  idx_t ptr, ptr_n, sel, sel_n, idle_sel, cur;
  node_word_t head [ncount];
  node_word_t w;
  logic [ncount-1:0] empty, afull, pop;
  logic found, avail, loadable, fwd, discard, drop_inc;
  for (genvar i = 0; i < ncount; i++) begin : g_node
    out_node_fifo #(.depth(fifo_depth), .af_margin(af_margin)) u_fifo (
      .clock(clock),
      .sclr(sclr),
      .wr(pnode_valid[i] && pnode_ready[i]),
      .rd(pop[i]),
      .din(node_word_t'(pnode_data[i])),
      .head(head[i]),
      .empty(empty[i]),
      .almost_full(afull[i])
    );
  end
  assign pnode_ready = sclr ? '0 : ~afull;
  always_comb begin
    found = 1'b0;
    idle_sel = '0;
    for (int k = 0; k < ncount; k++)
      if (!found && !empty[(int'(ptr) + k) % ncount]) begin
        found = 1'b1;
        idle_sel = idx_t'((int'(ptr) + k) % ncount);
      end
    cur = (state == LOCKED) ? sel : idle_sel;
    avail = (state == LOCKED) ? !empty[cur] : found;
    w = head[cur];
    loadable = !st_valid || st_ready;
    // headless words are discarded in IDLE without needing the output register
    fwd = avail && loadable && (state == LOCKED || w.sop);
    discard = avail && state == IDLE && !w.sop;
    drop_inc = discard || (fwd && state == LOCKED && w.sop);
    pop = '0;
    if (fwd || discard) pop[cur] = 1'b1;
    state_n = state;
    ptr_n = ptr;
    sel_n = sel;
    if (fwd && w.eop) begin
      state_n = IDLE;
      ptr_n = (cur == idx_t'(ncount - 1)) ? '0 : cur + idx_t'(1);
    end else if (fwd) begin
      state_n = LOCKED;
      sel_n = cur;
    end
  end
  always_ff @(posedge clock) begin
    if (sclr) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      st_valid <= 1'b0;
      st_sop <= 1'b0;
      st_eop <= 1'b0;
      st_channel <= '0;
      st_data <= '0;
      drop_count <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      sel <= sel_n;
      if (loadable) begin
        st_valid <= fwd;
        if (fwd) begin
          st_data <= to_st(w);
          st_sop <= w.sop;
          st_eop <= w.eop;
          st_channel <= w.channel;
        end
      end
      if (drop_inc && drop_count != 16'hffff) drop_count <= drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_out_fifo_network.sv
// tb_out_fifo_network: directed checks of arbitration, back-pressure, drops and reset
module tb_out_fifo_network;
  logic clock = 1'b0, sclr = 1'b1, st_ready = 1'b0;
  logic [141:0] pnode_data [8];
  logic [7:0] pnode_valid = '0, pnode_ready;
  logic [147:0] st_data;
  logic st_sop, st_eop, st_valid;
  logic [1:0] st_channel;
  logic [15:0] drop_count;
  int errors = 0, checks = 0;
  logic [141:0] w [16];
  logic [141:0] v [16];
  int wr, rd;
  logic rdy;

  always #5 clock = ~clock;

  out_fifo_network dut (
    .clock(clock), .sclr(sclr), .pnode_data(pnode_data), .pnode_valid(pnode_valid),
    .pnode_ready(pnode_ready), .st_data(st_data), .st_sop(st_sop), .st_eop(st_eop),
    .st_channel(st_channel), .st_valid(st_valid), .st_ready(st_ready), .drop_count(drop_count)
  );

  function automatic logic [141:0] mk(input int node, input int idx, input logic sop, input logic eop);
    logic [9:0] mid;
    mid = 10'(node * 16 + idx);
    return {2'(node), mid, sop, eop, {16'hA5A5, 38'h0, mid}, {16'h5A5A, 38'h0, mid} ^ 64'(node)};
  endfunction

  function automatic logic [152:0] exp_of(input logic [141:0] x);
    return {1'b1, x[129], x[128], x[141:140], 10'b0, x[127:64], x[139:130], x[63:0]};
  endfunction

  function automatic logic [152:0] obs();
    return {st_valid, st_sop, st_eop, st_channel, st_data};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [152:0] o, input logic [152:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  initial begin
    foreach (pnode_data[i]) pnode_data[i] = '0;
    tick();
    tick();
    chk("rst_valid", 153'(st_valid), 153'(0));
    chk("rst_data", 153'(st_data), 153'(0));
    chk("rst_drop", 153'(drop_count), 153'(0));
    chk("rst_ready", 153'(pnode_ready), 153'(0));
    sclr = 1'b0;
    #1;
    chk("rel_ready", 153'(pnode_ready), 153'(8'hFF));
    st_ready = 1'b1;
    // single node, 3-word packet: 2-cycle latency then one word per cycle
    for (int k = 0; k < 3; k++) w[k] = mk(2, k, k == 0, k == 2);
    for (int k = 0; k < 5; k++) begin
      pnode_valid[2] = (k < 3);
      if (k < 3) pnode_data[2] = w[k];
      tick();
      if (k >= 1 && k <= 3) chk($sformatf("t1_w%0d", k - 1), obs(), exp_of(w[k - 1]));
    end
    chk("t1_idle", 153'(st_valid), 153'(0));
    // nodes 0 and 1 contend: whole packet from 0, then 1, no gap
    for (int k = 0; k < 4; k++) begin
      w[k] = mk(0, k, k == 0, k == 3);
      v[k] = mk(1, k, k == 0, k == 3);
    end
    for (int k = 0; k < 10; k++) begin
      pnode_valid[1:0] = (k < 4) ? 2'b11 : 2'b00;
      if (k < 4) begin
        pnode_data[0] = w[k];
        pnode_data[1] = v[k];
      end
      tick();
      if (k >= 1 && k <= 8) chk($sformatf("t2_w%0d", k - 1), obs(), exp_of(k <= 4 ? w[k - 1] : v[k - 5]));
    end
    chk("t2_idle", 153'(st_valid), 153'(0));
    // pointer now 2: node 3 wins over node 0
    w[0] = mk(0, 8, 1'b1, 1'b1);
    v[0] = mk(3, 8, 1'b1, 1'b1);
    pnode_data[0] = w[0];
    pnode_data[3] = v[0];
    pnode_valid = 8'b0000_1001;
    tick();
    pnode_valid = '0;
    tick();
    chk("rr_first", obs(), exp_of(v[0]));
    tick();
    chk("rr_second", obs(), exp_of(w[0]));
    tick();
    chk("rr_idle", 153'(st_valid), 153'(0));
    // 8-word packet with st_ready toggling
    st_ready = 1'b0;
    for (int k = 0; k < 8; k++) w[k] = mk(4, k, k == 0, k == 7);
    for (int k = 0; k < 8; k++) begin
      pnode_valid[4] = 1'b1;
      pnode_data[4] = w[k];
      tick();
    end
    pnode_valid = '0;
    chk("t3_hold", obs(), exp_of(w[0]));
    for (int k = 0; k < 8; k++) begin
      st_ready = 1'b1;
      tick();
      if (k < 7) chk($sformatf("t3_w%0d", k + 1), obs(), exp_of(w[k + 1]));
      else chk("t3_end", 153'(st_valid), 153'(0));
      st_ready = 1'b0;
      tick();
      if (k < 7) chk($sformatf("t3_stall%0d", k + 1), obs(), exp_of(w[k + 1]));
      else chk("t3_end_stall", 153'(st_valid), 153'(0));
    end
    // headless word from node 5 is dropped, next packet passes
    st_ready = 1'b1;
    pnode_data[5] = mk(5, 0, 1'b0, 1'b0);
    pnode_valid[5] = 1'b1;
    tick();
    pnode_valid = '0;
    tick();
    chk("t4_drop", 153'(drop_count), 153'(1));
    chk("t4_novalid", 153'(st_valid), 153'(0));
    for (int k = 0; k < 2; k++) w[k] = mk(5, k + 1, k == 0, k == 1);
    for (int k = 0; k < 3; k++) begin
      pnode_valid[5] = (k < 2);
      if (k < 2) pnode_data[5] = w[k];
      tick();
      if (k >= 1) chk($sformatf("t4_w%0d", k - 1), obs(), exp_of(w[k - 1]));
    end
    tick();
    chk("t4_idle", 153'(st_valid), 153'(0));
    chk("t4_drop_kept", 153'(drop_count), 153'(1));
    // back-pressure: output register held by node 1, node 0 fills to margin
    st_ready = 1'b0;
    v[0] = mk(1, 9, 1'b1, 1'b1);
    pnode_data[1] = v[0];
    pnode_valid[1] = 1'b1;
    tick();
    pnode_valid = '0;
    tick();
    chk("t5_held", obs(), exp_of(v[0]));
    for (int k = 0; k < 14; k++) w[k] = mk(0, k, k == 0, k == 13);
    wr = 0;
    for (int c = 0; c < 16; c++) begin
      pnode_valid[0] = (wr < 14);
      if (wr < 14) pnode_data[0] = w[wr];
      rdy = pnode_ready[0];
      tick();
      if (rdy && wr < 14) wr++;
    end
    chk("t5_writes", 153'(wr), 153'(12));
    chk("t5_ready", 153'(pnode_ready), 153'(8'hFE));
    st_ready = 1'b1;
    rd = 0;
    for (int c = 0; c < 20 && rd < 14; c++) begin
      pnode_valid[0] = (wr < 14);
      if (wr < 14) pnode_data[0] = w[wr];
      rdy = pnode_ready[0];
      tick();
      if (rdy && wr < 14) wr++;
      chk($sformatf("t5_w%0d", rd), obs(), exp_of(w[rd]));
      rd++;
    end
    pnode_valid = '0;
    chk("t5_all_written", 153'(wr), 153'(14));
    tick();
    chk("t5_idle", 153'(st_valid), 153'(0));
    // sop inside a locked packet truncates it and counts a drop
    w[0] = mk(6, 0, 1'b1, 1'b0);
    w[1] = mk(6, 1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      pnode_valid[6] = (k < 2);
      if (k < 2) pnode_data[6] = w[k];
      tick();
      if (k >= 1) chk($sformatf("t6_w%0d", k - 1), obs(), exp_of(w[k - 1]));
    end
    chk("t6_drop", 153'(drop_count), 153'(2));
    tick();
    chk("t6_idle", 153'(st_valid), 153'(0));
    // sclr mid-packet
    for (int k = 0; k < 3; k++) w[k] = mk(2, k + 4, k == 0, 1'b0);
    pnode_valid[2] = 1'b1;
    pnode_data[2] = w[0];
    tick();
    pnode_data[2] = w[1];
    tick();
    chk("t7_pre", obs(), exp_of(w[0]));
    pnode_data[2] = w[2];
    sclr = 1'b1;
    #1;
    chk("t7_ready_low", 153'(pnode_ready), 153'(0));
    tick();
    chk("t7_valid", 153'(st_valid), 153'(0));
    chk("t7_data", 153'(st_data), 153'(0));
    chk("t7_drop", 153'(drop_count), 153'(0));
    sclr = 1'b0;
    pnode_valid = '0;
    #1;
    chk("t7_ready_high", 153'(pnode_ready), 153'(8'hFF));
    tick();
    tick();
    chk("t7_flushed", 153'(st_valid), 153'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
